// File: rtl/combo_digit_entry.sv
// Digit-entry buffer for the combination lock: captures one BCD digit per enter
// rising edge into a shift buffer, flagging completion and invalid digits.
module combo_digit_entry #(
  parameter int                 NUM_DIGITS = 6,
  parameter int                 DIGIT_W    = 4,
  parameter int                 MAX_DIGIT  = 9,
  parameter logic [DIGIT_W-1:0] BLANK      = 4'hF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          enter,
  input  logic                          clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [2:0]                    count,
  output logic                          entry_done,
  output logic                          entry_err,
  output logic [1:0]                    state
);

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] COLLECT = 2'b01;
  localparam logic [1:0] FULL    = 2'b10;
  localparam logic [1:0] ERROR   = 2'b11;

  localparam int                          BUF_W     = NUM_DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0]          MAX_D     = DIGIT_W'(MAX_DIGIT);
  localparam logic [2:0]                  FULL_CNT  = 3'(NUM_DIGITS);
  localparam logic [BUF_W-1:0]            ALL_BLANK = {NUM_DIGITS{BLANK}};

  logic              enter_q;
  logic              enter_rise;
  logic              digit_ok;
  logic [2:0]        count_inc;

  logic [1:0]        state_n;
  logic [BUF_W-1:0]  digits_n;
  logic [2:0]        count_n;
  logic              done_n;
  logic              err_n;

  assign enter_rise = enter & ~enter_q;
  assign digit_ok   = (digit_in <= MAX_D);
  assign count_inc  = count + 3'd1;

  // NOTE: every signal assigned in always_comb gets a default up front, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    digits_n = digits;
    count_n  = count;
    err_n    = entry_err;
    done_n   = 1'b0;

    if (clear) begin
      state_n  = EMPTY;
      digits_n = ALL_BLANK;
      count_n  = 3'd0;
      err_n    = 1'b0;
    end else if (enter_rise) begin
      case (state)
        EMPTY, COLLECT: begin
          if (digit_ok) begin
            digits_n = {digits[BUF_W-DIGIT_W-1:0], digit_in};
            count_n  = count_inc;
            if (count_inc == FULL_CNT) begin
              state_n = FULL;
              done_n  = 1'b1;
            end else begin
              state_n = COLLECT;
            end
          end else begin
            state_n = ERROR;
            err_n   = 1'b1;
          end
        end
        // FULL and ERROR are sticky until clear; enter rises are dropped.
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // The digit buffer is reset as well: the display and lock FSM read it
  // directly, so it must show BLANK the instant reset is applied.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enter_q    <= 1'b0;
      state      <= EMPTY;
      digits     <= ALL_BLANK;
      count      <= 3'd0;
      entry_done <= 1'b0;
      entry_err  <= 1'b0;
    end else begin
      enter_q    <= enter;
      state      <= state_n;
      digits     <= digits_n;
      count      <= count_n;
      entry_done <= done_n;
      entry_err  <= err_n;
    end
  end

endmodule
